vld_rdy_out_buffer: RTL



---
 rtl/vld_rdy_out_buffer_pkg.sv | 16 +
 rtl/vld_rdy_out_buffer_mem.sv | 38 +++
 rtl/vld_rdy_out_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vld_rdy_out_buffer_pkg.sv
// Shared constants, types and helpers for the valid/ready output buffer.
// Optional drop counter is enabled with VLD_RDY_OUT_BUFFER_OVF_CNT_EN.
package vld_rdy_out_buffer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 16;
    localparam int unsigned OVF_CNT_W      = 16;

    typedef logic [$clog2(DEPTH_DEF):0] level_t;

    // Next pointer value, wrapping modulo a power-of-two depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/vld_rdy_out_buffer_mem.sv
// Dual-port register array: one write port, one registered read port with
// write-through so a word written into the addressed slot appears next cycle.
module vld_rdy_out_buffer_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PTR_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vld_rdy_out_buffer.sv
// Circular FIFO turning a no-backpressure valid stream into valid/ready,
// with sticky overflow flag; VLD_RDY_OUT_BUFFER_OVF_CNT_EN adds a drop counter.
module vld_rdy_out_buffer
    import vld_rdy_out_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned AFULL_LVL  = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         data_in_vld,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         data_out_vld,
    output logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         data_out_rdy,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         afull,
    output logic                         ovf_flag,
    input  logic                         ovf_clr
`ifdef VLD_RDY_OUT_BUFFER_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]         ovf_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_vld;
    logic             r_afull;
    logic             r_ovf;

    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_afull_nxt;
    logic             w_ovf_nxt;

    // A read frees a slot in the same cycle, so a full buffer still accepts a write.
    always_comb begin
        w_rd         = r_vld & data_out_rdy;
        w_wr         = data_in_vld & ((r_level != LVL_W'(DEPTH)) | w_rd);
        w_drop       = data_in_vld & ~w_wr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_wr) begin
            w_wr_ptr_nxt = PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
        end
        if (w_rd) begin
            w_rd_ptr_nxt = PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
        end
        case ({w_wr, w_rd})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
        w_afull_nxt = (32'(w_level_nxt) >= AFULL_LVL);
        w_ovf_nxt   = w_drop | (r_ovf & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_vld    <= 1'b0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_vld    <= (w_level_nxt != '0);
            r_afull  <= w_afull_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // Read port addresses the next head so data_out tracks it one cycle later.
    vld_rdy_out_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (data_out)
    );

    assign data_out_vld = r_vld;
    assign level        = r_level;
    assign afull        = r_afull;
    assign ovf_flag     = r_ovf;

`ifdef VLD_RDY_OUT_BUFFER_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;
    logic [OVF_CNT_W-1:0] w_ovf_cnt_nxt;

    // Clear and drop together restart the count at one; otherwise saturate.
    always_comb begin
        w_ovf_cnt_nxt = r_ovf_cnt;
        if (ovf_clr) begin
            w_ovf_cnt_nxt = w_drop ? OVF_CNT_W'(1) : '0;
        end else if (w_drop && (r_ovf_cnt != '1)) begin
            w_ovf_cnt_nxt = r_ovf_cnt + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else begin
            r_ovf_cnt <= w_ovf_cnt_nxt;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
